// File: rtl/seq_control_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// seq_control_pkg : state, opcode and mux-select encodings for seq_control
// rev 1.0
// ----------------------------------------------------------------------------
package seq_control_pkg;

  typedef enum logic [4:0] {
    ST_START    = 5'd0,
    ST_PREPU    = 5'd1,
    ST_FETCHU   = 5'd2,
    ST_PREPL    = 5'd3,
    ST_FETCHL   = 5'd4,
    ST_EXEC1    = 5'd5,
    ST_IMM      = 5'd6,
    ST_MEMRD    = 5'd7,
    ST_STORE    = 5'd8,
    ST_BRANCH   = 5'd9,
    ST_LDSP     = 5'd10,
    ST_PUSH_DEC = 5'd11,
    ST_PUSH_WR  = 5'd12,
    ST_POP_RD   = 5'd13,
    ST_POP_INC  = 5'd14,
    ST_JSR_DEC  = 5'd15,
    ST_JSR_WR   = 5'd16,
    ST_JSR_JMP  = 5'd17,
    ST_RTS_RD   = 5'd18,
    ST_RTS_INC  = 5'd19
  } state_t;

  localparam logic [4:0] OP_00 = 5'h00, OP_01 = 5'h01, OP_02 = 5'h02, OP_03 = 5'h03;
  localparam logic [4:0] OP_04 = 5'h04, OP_05 = 5'h05, OP_06 = 5'h06, OP_07 = 5'h07;
  localparam logic [4:0] OP_08 = 5'h08, OP_09 = 5'h09, OP_0A = 5'h0A, OP_0B = 5'h0B;
  localparam logic [4:0] OP_0C = 5'h0C, OP_0D = 5'h0D, OP_0E = 5'h0E, OP_0F = 5'h0F;
  localparam logic [4:0] OP_10 = 5'h10, OP_11 = 5'h11, OP_12 = 5'h12, OP_13 = 5'h13;
  localparam logic [4:0] OP_14 = 5'h14, OP_15 = 5'h15, OP_16 = 5'h16, OP_17 = 5'h17;
  localparam logic [4:0] OP_18 = 5'h18, OP_19 = 5'h19;

  localparam logic [1:0] ADDR_PC  = 2'd0;
  localparam logic [1:0] ADDR_IRL = 2'd1;
  localparam logic [1:0] ADDR_SP  = 2'd2;

  localparam logic WDATA_AC = 1'b0;
  localparam logic WDATA_PC = 1'b1;

  // Opcode classes that share a datapath sequence
  function automatic logic is_exec1(input logic [4:0] op);
    return op inside {OP_00, OP_04};
  endfunction

  function automatic logic is_imm(input logic [4:0] op);
    return op inside {OP_02, OP_06, OP_08, OP_0E, OP_0F};
  endfunction

  function automatic logic is_memrd(input logic [4:0] op);
    return op inside {OP_01, OP_05, OP_07, OP_09, OP_0A, OP_0B, OP_0C, OP_0D};
  endfunction

  function automatic logic is_branch(input logic [4:0] op);
    return op inside {OP_10, OP_11, OP_12, OP_13, OP_14};
  endfunction

endpackage

`default_nettype wire

// File: rtl/seq_stack_ptr.sv
`default_nettype none
// ----------------------------------------------------------------------------
// seq_stack_ptr : stack pointer, live-word count, full/empty and sticky errors
// rev 1.0
// ----------------------------------------------------------------------------
module seq_stack_ptr
  import seq_control_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int SP_INIT     = 255,
  parameter int STACK_DEPTH = 16
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               load,
  input  logic [ADDR_W-1:0]                  load_val,
  input  logic                               dec,
  input  logic                               inc,
  input  logic                               set_ovf,
  input  logic                               set_unf,
  output logic [ADDR_W-1:0]                  sp,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   cnt,
  output logic                               full,
  output logic                               empty,
  output logic                               ovf,
  output logic                               unf
);

  localparam int CNT_W = $clog2(STACK_DEPTH + 1);

  // SP arithmetic wraps naturally at ADDR_W bits; wrap is not an error
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sp  <= ADDR_W'(SP_INIT);
      cnt <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      if (load) begin
        sp  <= load_val;
        cnt <= '0;
      end else if (dec) begin
        sp  <= sp - ADDR_W'(1);
        cnt <= cnt + CNT_W'(1);
      end else if (inc) begin
        sp  <= sp + ADDR_W'(1);
        cnt <= cnt - CNT_W'(1);
      end
      if (set_ovf) ovf <= 1'b1;
      if (set_unf) unf <= 1'b1;
    end
  end

  assign full  = (cnt == CNT_W'(STACK_DEPTH));
  assign empty = (cnt == '0);

endmodule

`default_nettype wire

// File: rtl/seq_control.sv
`default_nettype none
// ----------------------------------------------------------------------------
// seq_control : multi-cycle instruction sequencer with hardware stack control
// rev 1.0
// ----------------------------------------------------------------------------
module seq_control
  import seq_control_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int SP_INIT     = 255,
  parameter int STACK_DEPTH = 16,
  parameter int WAIT_EN     = 1
) (
  input  logic                               CLK,
  input  logic                               RESET_N,
  input  logic [7:0]                         OPCODE,
  input  logic [ADDR_W-1:0]                  IRL,
  input  logic                               ZFLG,
  input  logic                               NFLG,
  input  logic                               MEM_READY,
  output logic                               FETCH,
  output logic                               INC_PC,
  output logic                               LOAD_IRU,
  output logic                               LOAD_IRL,
  output logic                               LOAD_AC,
  output logic                               STORE_MEM,
  output logic                               MEM_READ,
  output logic                               LOAD_PC,
  output logic                               PC_SRC,
  output logic [1:0]                         ADDR_SEL,
  output logic                               WDATA_SEL,
  output logic [ADDR_W-1:0]                  SP,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   STACK_CNT,
  output logic                               STK_OVF,
  output logic                               STK_UNF,
  output logic                               ILLEGAL,
  output logic [4:0]                         STATE
);

  state_t     state, state_nxt;
  logic [4:0] op;
  logic       rdy;
  logic       sp_load, sp_dec, sp_inc, set_ovf, set_unf;
  logic       stk_full, stk_empty;
  logic       unused_opcode_hi;

  assign op               = OPCODE[4:0];
  assign rdy              = (WAIT_EN == 0) ? 1'b1 : MEM_READY;
  assign unused_opcode_hi = ^OPCODE[7:5];
  assign STATE            = state;

  seq_stack_ptr #(
    .ADDR_W      (ADDR_W),
    .SP_INIT     (SP_INIT),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk      (CLK),
    .reset_n  (RESET_N),
    .load     (sp_load),
    .load_val (IRL),
    .dec      (sp_dec),
    .inc      (sp_inc),
    .set_ovf  (set_ovf),
    .set_unf  (set_unf),
    .sp       (SP),
    .cnt      (STACK_CNT),
    .full     (stk_full),
    .empty    (stk_empty),
    .ovf      (STK_OVF),
    .unf      (STK_UNF)
  );

  always_ff @(posedge CLK) begin
    if (!RESET_N) state <= ST_START;
    else          state <= state_nxt;
  end

  // Every strobe is forced low while RESET_N is low, even mid-instruction
  always_comb begin
    state_nxt = state;
    FETCH     = 1'b0;
    INC_PC    = 1'b0;
    LOAD_IRU  = 1'b0;
    LOAD_IRL  = 1'b0;
    LOAD_AC   = 1'b0;
    STORE_MEM = 1'b0;
    MEM_READ  = 1'b0;
    LOAD_PC   = 1'b0;
    PC_SRC    = 1'b0;
    ADDR_SEL  = ADDR_PC;
    WDATA_SEL = WDATA_AC;
    ILLEGAL   = 1'b0;
    sp_load   = 1'b0;
    sp_dec    = 1'b0;
    sp_inc    = 1'b0;
    set_ovf   = 1'b0;
    set_unf   = 1'b0;
    if (RESET_N) begin
      case (state)
        ST_START: state_nxt = ST_PREPU;
        ST_PREPU: begin
          FETCH     = 1'b1;
          state_nxt = ST_FETCHU;
        end
        ST_FETCHU: begin
          FETCH    = 1'b1;
          MEM_READ = 1'b1;
          if (rdy) begin
            INC_PC    = 1'b1;
            LOAD_IRU  = 1'b1;
            state_nxt = is_exec1(op) ? ST_EXEC1 : ST_PREPL;
          end
        end
        ST_PREPL: begin
          FETCH     = 1'b1;
          state_nxt = ST_FETCHL;
        end
        ST_FETCHL: begin
          FETCH    = 1'b1;
          MEM_READ = 1'b1;
          if (rdy) begin
            INC_PC    = 1'b1;
            LOAD_IRL  = 1'b1;
            state_nxt = ST_PREPU;
            if (is_imm(op))         state_nxt = ST_IMM;
            else if (is_memrd(op))  state_nxt = ST_MEMRD;
            else if (op == OP_03)   state_nxt = ST_STORE;
            else if (is_branch(op)) state_nxt = ST_BRANCH;
            else begin
              // Stack faults are caught here so the aborted op never touches SP
              case (op)
                OP_15: state_nxt = ST_LDSP;
                OP_16, OP_18: begin
                  if (stk_full) set_ovf   = 1'b1;
                  else          state_nxt = (op == OP_16) ? ST_PUSH_DEC : ST_JSR_DEC;
                end
                OP_17, OP_19: begin
                  if (stk_empty) set_unf   = 1'b1;
                  else           state_nxt = (op == OP_17) ? ST_POP_RD : ST_RTS_RD;
                end
                default: ILLEGAL = (op > OP_19);
              endcase
            end
          end
        end
        ST_EXEC1, ST_IMM: begin
          LOAD_AC   = 1'b1;
          state_nxt = ST_PREPU;
        end
        ST_MEMRD: begin
          ADDR_SEL = ADDR_IRL;
          MEM_READ = 1'b1;
          if (rdy) begin
            LOAD_AC   = 1'b1;
            state_nxt = ST_PREPU;
          end
        end
        ST_STORE: begin
          ADDR_SEL  = ADDR_IRL;
          STORE_MEM = 1'b1;
          if (rdy) state_nxt = ST_PREPU;
        end
        ST_BRANCH: begin
          case (op)
            OP_10:   LOAD_PC = 1'b1;
            OP_11:   LOAD_PC = NFLG;
            OP_12:   LOAD_PC = !NFLG;
            OP_13:   LOAD_PC = ZFLG;
            OP_14:   LOAD_PC = !ZFLG;
            default: LOAD_PC = 1'b0;
          endcase
          state_nxt = ST_PREPU;
        end
        ST_LDSP: begin
          sp_load   = 1'b1;
          state_nxt = ST_PREPU;
        end
        ST_PUSH_DEC, ST_JSR_DEC: begin
          sp_dec    = 1'b1;
          state_nxt = (state == ST_PUSH_DEC) ? ST_PUSH_WR : ST_JSR_WR;
        end
        ST_PUSH_WR, ST_JSR_WR: begin
          ADDR_SEL  = ADDR_SP;
          WDATA_SEL = (state == ST_JSR_WR) ? WDATA_PC : WDATA_AC;
          STORE_MEM = 1'b1;
          if (rdy) state_nxt = (state == ST_JSR_WR) ? ST_JSR_JMP : ST_PREPU;
        end
        ST_JSR_JMP: begin
          LOAD_PC   = 1'b1;
          state_nxt = ST_PREPU;
        end
        ST_POP_RD, ST_RTS_RD: begin
          ADDR_SEL = ADDR_SP;
          MEM_READ = 1'b1;
          if (rdy) begin
            if (state == ST_POP_RD) begin
              LOAD_AC   = 1'b1;
              state_nxt = ST_POP_INC;
            end else begin
              LOAD_PC   = 1'b1;
              PC_SRC    = 1'b1;
              state_nxt = ST_RTS_INC;
            end
          end
        end
        ST_POP_INC, ST_RTS_INC: begin
          sp_inc    = 1'b1;
          state_nxt = ST_PREPU;
        end
        default: state_nxt = ST_START;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seq_control.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_seq_control : directed and randomized instruction-level checks of seq_control
// rev 1.0
// ----------------------------------------------------------------------------
module tb_seq_control;
  import seq_control_pkg::*;

  localparam int DEPTH = 2;

  logic       CLK;
  logic       RESET_N;
  logic [7:0] OPCODE;
  logic [7:0] IRL;
  logic       ZFLG, NFLG, MEM_READY;
  logic       FETCH, INC_PC, LOAD_IRU, LOAD_IRL, LOAD_AC, STORE_MEM, MEM_READ;
  logic       LOAD_PC, PC_SRC, WDATA_SEL, STK_OVF, STK_UNF, ILLEGAL;
  logic [1:0] ADDR_SEL;
  logic [7:0] SP;
  logic [1:0] STACK_CNT;
  logic [4:0] STATE;

  seq_control #(
    .ADDR_W      (8),
    .SP_INIT     (255),
    .STACK_DEPTH (DEPTH),
    .WAIT_EN     (1)
  ) dut (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .OPCODE    (OPCODE),
    .IRL       (IRL),
    .ZFLG      (ZFLG),
    .NFLG      (NFLG),
    .MEM_READY (MEM_READY),
    .FETCH     (FETCH),
    .INC_PC    (INC_PC),
    .LOAD_IRU  (LOAD_IRU),
    .LOAD_IRL  (LOAD_IRL),
    .LOAD_AC   (LOAD_AC),
    .STORE_MEM (STORE_MEM),
    .MEM_READ  (MEM_READ),
    .LOAD_PC   (LOAD_PC),
    .PC_SRC    (PC_SRC),
    .ADDR_SEL  (ADDR_SEL),
    .WDATA_SEL (WDATA_SEL),
    .SP        (SP),
    .STACK_CNT (STACK_CNT),
    .STK_OVF   (STK_OVF),
    .STK_UNF   (STK_UNF),
    .ILLEGAL   (ILLEGAL),
    .STATE     (STATE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Per-instruction event tally: what the datapath would have seen happen
  typedef struct packed {
    logic [7:0] iru, irl, inc, ldac, pc0, pc1, ill;
    logic [7:0] wr_irl, wr_sp_ac, wr_sp_pc, wr_bad;
    logic [7:0] rd_pc, rd_irl, rd_sp, rd_bad;
  } ev_t;

  int   tot = 0;
  int   bad = 0;
  ev_t  obs;
  int   obs_cyc, obs_st_cyc, obs_st_sp;
  bit   obs_to;

  function automatic logic [12:0] strobes();
    return {FETCH, INC_PC, LOAD_IRU, LOAD_IRL, LOAD_AC, STORE_MEM, MEM_READ,
            LOAD_PC, PC_SRC, ADDR_SEL, WDATA_SEL, ILLEGAL};
  endfunction

  // Expected instruction effects, from the opcode table and stack rules
  function automatic ev_t expect_ev(input logic [4:0] o, input logic z, input logic n, input int cnt);
    ev_t e;
    e = '0;
    e.iru = 1; e.inc = 1; e.rd_pc = 1;
    if (o == 5'h00 || o == 5'h04) begin
      e.ldac = 1;
    end else begin
      e.irl = 1; e.inc = 2; e.rd_pc = 2;
      if (o inside {5'h02, 5'h06, 5'h08, 5'h0E, 5'h0F}) e.ldac = 1;
      else if (o inside {5'h01, 5'h05, 5'h07, [5'h09:5'h0D]}) begin e.ldac = 1; e.rd_irl = 1; end
      else if (o == 5'h03) e.wr_irl = 1;
      else if (o == 5'h10) e.pc0 = 1;
      else if (o == 5'h11) e.pc0 = {7'd0, n};
      else if (o == 5'h12) e.pc0 = {7'd0, !n};
      else if (o == 5'h13) e.pc0 = {7'd0, z};
      else if (o == 5'h14) e.pc0 = {7'd0, !z};
      else if (o == 5'h15) e.ldac = 0;
      else if (o == 5'h16) begin if (cnt < DEPTH) e.wr_sp_ac = 1; end
      else if (o == 5'h17) begin if (cnt > 0) begin e.rd_sp = 1; e.ldac = 1; end end
      else if (o == 5'h18) begin if (cnt < DEPTH) begin e.wr_sp_pc = 1; e.pc0 = 1; end end
      else if (o == 5'h19) begin if (cnt > 0) begin e.rd_sp = 1; e.pc1 = 1; end end
      else e.ill = 1;
    end
    return e;
  endfunction

  task automatic do_reset();
    @(negedge CLK);
    RESET_N = 1'b0; MEM_READY = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    RESET_N = 1'b1;
    @(negedge CLK);
  endtask

  // Runs one instruction from the PREPU cycle until PREPU comes round again
  task automatic run_instr(input logic [7:0] op, input logic [7:0] irl, input logic z,
                           input logic n, input int rdy_pct, input int store_hold);
    int  hold;
    bit  done;
    obs = '0; obs_cyc = 0; obs_st_cyc = 0; obs_st_sp = 0; obs_to = 0;
    OPCODE = op; IRL = irl; ZFLG = z; NFLG = n;
    hold = store_hold; done = 0;
    while (!done) begin
      @(negedge CLK);
      MEM_READY = 1'b1;
      #1;
      if (STORE_MEM && hold > 0) begin MEM_READY = 1'b0; hold--; end
      else if (rdy_pct < 100) MEM_READY = ($urandom_range(99) < rdy_pct);
      #1;
      if (STATE == ST_PREPU) done = 1;
      else begin
        obs_cyc++;
        if (LOAD_IRU) obs.iru  = obs.iru + 1;
        if (LOAD_IRL) obs.irl  = obs.irl + 1;
        if (INC_PC)   obs.inc  = obs.inc + 1;
        if (LOAD_AC)  obs.ldac = obs.ldac + 1;
        if (ILLEGAL)  obs.ill  = obs.ill + 1;
        if (LOAD_PC) begin
          if (PC_SRC) obs.pc1 = obs.pc1 + 1;
          else        obs.pc0 = obs.pc0 + 1;
        end
        if (STORE_MEM) begin
          obs_st_cyc++;
          if (ADDR_SEL == 2'd2) obs_st_sp++;
          if (MEM_READY) begin
            case ({ADDR_SEL, WDATA_SEL})
              3'b010:  obs.wr_irl   = obs.wr_irl + 1;
              3'b100:  obs.wr_sp_ac = obs.wr_sp_ac + 1;
              3'b101:  obs.wr_sp_pc = obs.wr_sp_pc + 1;
              default: obs.wr_bad   = obs.wr_bad + 1;
            endcase
          end
        end
        if (MEM_READ && MEM_READY) begin
          case (ADDR_SEL)
            2'd0:    obs.rd_pc  = obs.rd_pc + 1;
            2'd1:    obs.rd_irl = obs.rd_irl + 1;
            2'd2:    obs.rd_sp  = obs.rd_sp + 1;
            default: obs.rd_bad = obs.rd_bad + 1;
          endcase
        end
        if (obs_cyc > 200) begin obs_to = 1; done = 1; end
      end
    end
  endtask

  task automatic test_reset();
    RESET_N = 1'b0; MEM_READY = 1'b0; OPCODE = 8'h00; IRL = 8'h00; ZFLG = 0; NFLG = 0;
    repeat (3) @(negedge CLK);
    #1;
    tot++; if ({STATE, SP, STACK_CNT, STK_OVF, STK_UNF} !== {ST_START, 8'hFF, 2'd0, 2'b00}) begin
      bad++; $display("FAIL reset_state: got %h want %h", {STATE, SP, STACK_CNT, STK_OVF, STK_UNF},
                      {ST_START, 8'hFF, 2'd0, 2'b00});
    end
    tot++; if (strobes() !== 13'd0) begin
      bad++; $display("FAIL reset_strobes: got %h want 0", strobes());
    end
    @(negedge CLK); RESET_N = 1'b1; #1;
    tot++; if (STATE !== ST_START) begin
      bad++; $display("FAIL reset_first_cycle: got %0d want %0d", STATE, ST_START);
    end
    @(negedge CLK); #1;
    tot++; if ({STATE, FETCH, ADDR_SEL} !== {ST_PREPU, 1'b1, 2'd0}) begin
      bad++; $display("FAIL reset_prepu: got %h want %h", {STATE, FETCH, ADDR_SEL}, {ST_PREPU, 1'b1, 2'd0});
    end
  endtask

  task automatic test_push_wait();
    ev_t e;
    do_reset();
    e = expect_ev(5'h16, 0, 0, 0);
    run_instr(8'h16, 8'h00, 0, 0, 100, 3);
    tot++; if ({SP, STACK_CNT} !== {8'hFE, 2'd1}) begin
      bad++; $display("FAIL push_wait_sp_cnt: got %h want %h", {SP, STACK_CNT}, {8'hFE, 2'd1});
    end
    tot++; if (obs_st_cyc !== 4 || obs_st_sp !== 4) begin
      bad++; $display("FAIL push_wait_store_cycles: got %0d/%0d want 4/4", obs_st_cyc, obs_st_sp);
    end
    tot++; if (obs !== e || obs_to) begin
      bad++; $display("FAIL push_wait_events: got %h want %h", obs, e);
    end
  endtask

  task automatic test_sp_wrap();
    do_reset();
    run_instr(8'h15, 8'h00, 0, 0, 100, 0);
    tot++; if ({SP, STACK_CNT} !== {8'h00, 2'd0}) begin
      bad++; $display("FAIL ldsp: got %h want %h", {SP, STACK_CNT}, {8'h00, 2'd0});
    end
    run_instr(8'h16, 8'h00, 0, 0, 70, 0);
    tot++; if ({SP, STACK_CNT, STK_OVF} !== {8'hFF, 2'd1, 1'b0}) begin
      bad++; $display("FAIL sp_wrap: got %h want %h", {SP, STACK_CNT, STK_OVF}, {8'hFF, 2'd1, 1'b0});
    end
  endtask

  task automatic test_overflow();
    ev_t e;
    do_reset();
    run_instr(8'h16, 8'h11, 0, 0, 100, 0);
    run_instr(8'h16, 8'h22, 0, 0, 100, 0);
    tot++; if ({SP, STACK_CNT, STK_OVF} !== {8'hFD, 2'd2, 1'b0}) begin
      bad++; $display("FAIL ovf_two_pushes: got %h want %h", {SP, STACK_CNT, STK_OVF}, {8'hFD, 2'd2, 1'b0});
    end
    e = expect_ev(5'h16, 0, 0, DEPTH);
    run_instr(8'h16, 8'h33, 0, 0, 100, 0);
    tot++; if ({SP, STACK_CNT, STK_OVF} !== {8'hFD, 2'd2, 1'b1}) begin
      bad++; $display("FAIL ovf_third_push: got %h want %h", {SP, STACK_CNT, STK_OVF}, {8'hFD, 2'd2, 1'b1});
    end
    tot++; if (obs !== e || obs_st_cyc !== 0) begin
      bad++; $display("FAIL ovf_no_write: got %h st=%0d want %h st=0", obs, obs_st_cyc, e);
    end
  endtask

  task automatic test_jsr_rts();
    ev_t e;
    do_reset();
    e = expect_ev(5'h18, 0, 0, 0);
    run_instr(8'h18, 8'h40, 0, 0, 60, 1);
    tot++; if (obs !== e || obs_to) begin
      bad++; $display("FAIL jsr_events: got %h want %h", obs, e);
    end
    tot++; if ({SP, STACK_CNT} !== {8'hFE, 2'd1}) begin
      bad++; $display("FAIL jsr_sp: got %h want %h", {SP, STACK_CNT}, {8'hFE, 2'd1});
    end
    e = expect_ev(5'h19, 0, 0, 1);
    run_instr(8'h19, 8'h00, 0, 0, 60, 0);
    tot++; if (obs !== e || obs_to) begin
      bad++; $display("FAIL rts_events: got %h want %h", obs, e);
    end
    tot++; if ({SP, STACK_CNT, STK_UNF} !== {8'hFF, 2'd0, 1'b0}) begin
      bad++; $display("FAIL rts_sp: got %h want %h", {SP, STACK_CNT, STK_UNF}, {8'hFF, 2'd0, 1'b0});
    end
  endtask

  task automatic test_underflow_illegal();
    ev_t e;
    do_reset();
    e = expect_ev(5'h17, 0, 0, 0);
    run_instr(8'h17, 8'h00, 0, 0, 100, 0);
    tot++; if (obs !== e || {SP, STACK_CNT, STK_UNF} !== {8'hFF, 2'd0, 1'b1}) begin
      bad++; $display("FAIL pop_underflow: got %h %h want %h %h", obs, {SP, STACK_CNT, STK_UNF}, e,
                      {8'hFF, 2'd0, 1'b1});
    end
    e = expect_ev(5'h1C, 0, 0, 0);
    run_instr(8'h1C, 8'h00, 0, 0, 100, 0);
    tot++; if (obs !== e || obs_cyc !== 3) begin
      bad++; $display("FAIL illegal: got %h cyc=%0d want %h cyc=3", obs, obs_cyc, e);
    end
  endtask

  task automatic test_reset_mid();
    bit found;
    do_reset();
    OPCODE = 8'h18; IRL = 8'h40; MEM_READY = 1'b1; found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge CLK); #1;
      if (STATE == ST_JSR_WR) found = 1;
    end
    MEM_READY = 1'b0;
    tot++; if (!found) begin
      bad++; $display("FAIL reset_mid_reach: got state %0d want %0d", STATE, ST_JSR_WR);
    end
    @(negedge CLK);
    RESET_N = 1'b0; #1;
    tot++; if (strobes() !== 13'd0) begin
      bad++; $display("FAIL reset_mid_strobes: got %h want 0", strobes());
    end
    @(negedge CLK); #1;
    tot++; if ({STATE, SP, STACK_CNT, strobes()} !== {ST_START, 8'hFF, 2'd0, 13'd0}) begin
      bad++; $display("FAIL reset_mid_state: got %h want %h", {STATE, SP, STACK_CNT, strobes()},
                      {ST_START, 8'hFF, 2'd0, 13'd0});
    end
    RESET_N = 1'b1; MEM_READY = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_random();
    int         m_sp, m_cnt;
    bit         m_ovf, m_unf;
    ev_t        e;
    logic [7:0] op, irl;
    logic       z, n;
    int         pct;
    m_sp = 255; m_cnt = 0; m_ovf = 0; m_unf = 0;
    do_reset();
    for (int i = 0; i < 150; i++) begin
      if (i % 50 == 49) begin
        do_reset();
        m_sp = 255; m_cnt = 0; m_ovf = 0; m_unf = 0;
      end
      op = 8'($urandom);
      if ($urandom_range(9) < 4) op[4:0] = 5'(5'h16 + $urandom_range(3));
      else if ($urandom_range(9) == 0) op[4:0] = 5'h15;
      irl = 8'($urandom);
      z = 1'($urandom); n = 1'($urandom);
      pct = $urandom_range(100, 40);
      e = expect_ev(op[4:0], z, n, m_cnt);
      run_instr(op, irl, z, n, pct, 0);
      case (op[4:0])
        5'h15: begin m_sp = irl; m_cnt = 0; end
        5'h16, 5'h18: begin
          if (m_cnt < DEPTH) begin m_sp = (m_sp + 255) % 256; m_cnt++; end
          else m_ovf = 1;
        end
        5'h17, 5'h19: begin
          if (m_cnt > 0) begin m_sp = (m_sp + 1) % 256; m_cnt--; end
          else m_unf = 1;
        end
        default: ;
      endcase
      tot++; if (obs !== e || obs_to) begin
        bad++; $display("FAIL rand_events[%0d] op=%h: got %h want %h to=%0d", i, op, obs, e, obs_to);
      end
      tot++; if ({SP, STACK_CNT, STK_OVF, STK_UNF} !== {8'(m_sp), 2'(m_cnt), m_ovf, m_unf}) begin
        bad++; $display("FAIL rand_stack[%0d] op=%h: got %h want %h", i, op,
                        {SP, STACK_CNT, STK_OVF, STK_UNF}, {8'(m_sp), 2'(m_cnt), m_ovf, m_unf});
      end
    end
  endtask

  initial begin
    test_reset();
    test_push_wait();
    test_sp_wrap();
    test_overflow();
    test_jsr_rts();
    test_underflow_illegal();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", tot, bad);
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/seq_control.md
SEQ_CONTROL -- requirements
Module: seq_control

Interface
REQ-001 Parameter ADDR_W, default 8, width of SP, IRL operand and memory address.
REQ-002 Parameter SP_INIT, default 255, SP value after reset.
REQ-003 Parameter STACK_DEPTH, default 16, maximum number of live stack words (1..2^ADDR_W-1).
REQ-004 Parameter WAIT_EN, default 1; 1 = memory states honour MEM_READY, 0 = MEM_READY treated as constant 1.
REQ-005 Ports, one per line, name direction width meaning:
  CLK  in  1  clock, all state changes on rising edge.
  RESET_N  in  1  reset; one clock; reset is synchronous and active-low.
  OPCODE  in  8  instruction upper byte (IRU); decode uses OPCODE[4:0].
  IRL  in  ADDR_W  instruction lower byte/operand.
  ZFLG, NFLG  in  1 each  accumulator zero / negative flags.
  MEM_READY  in  1  memory completes current read/write this cycle.
  FETCH, INC_PC, LOAD_IRU, LOAD_IRL, LOAD_AC, STORE_MEM, MEM_READ  out  1 each  datapath strobes.
  LOAD_PC  out  1  load PC; PC_SRC  out  1  0 = IRL, 1 = memory read data.
  ADDR_SEL  out  2  address mux: 0 = PC, 1 = IRL, 2 = SP.
  WDATA_SEL  out  1  write data: 0 = AC, 1 = PC.
  SP  out  ADDR_W  stack pointer; STACK_CNT  out  clog2(STACK_DEPTH+1)  live words.
  STK_OVF, STK_UNF  out  1 each  sticky stack overflow / underflow.
  ILLEGAL  out  1  one-cycle pulse on undefined opcode.
  STATE  out  5  current state encoding.

Function
REQ-006 States: START, PREPU, FETCHU, PREPL, FETCHL, EXEC1, IMM, MEMRD, STORE, BRANCH, LDSP, PUSH_DEC, PUSH_WR, POP_RD, POP_INC, JSR_DEC, JSR_WR, JSR_JMP, RTS_RD, RTS_INC.
REQ-007 START -> PREPU unconditionally; PREPU asserts FETCH, ADDR_SEL=0, -> FETCHU.
REQ-008 FETCHU/FETCHL assert FETCH, MEM_READ, ADDR_SEL=0; hold while MEM_READY=0; on ready cycle assert INC_PC and LOAD_IRU (resp. LOAD_IRL) and advance.
REQ-009 FETCHU exit: OPCODE[4:0] in {00,04} -> EXEC1, else PREPL; PREPL asserts FETCH -> FETCHL.
REQ-010 FETCHL exit: {02,06,08,0E,0F} -> IMM; {01,05,07,09..0D} -> MEMRD; 03 -> STORE; 10..14 -> BRANCH; 15 -> LDSP; 16 -> PUSH_DEC; 17 -> POP_RD; 18 -> JSR_DEC; 19 -> RTS_RD; 1A..1F -> ILLEGAL pulse, PREPU.
REQ-011 EXEC1 and IMM assert LOAD_AC one cycle -> PREPU.
REQ-012 MEMRD: ADDR_SEL=1, MEM_READ; LOAD_AC only in ready cycle, then PREPU. STORE: ADDR_SEL=1, WDATA_SEL=0, STORE_MEM until ready, then PREPU.
REQ-013 BRANCH: LOAD_PC, PC_SRC=0 when 10 always, 11 NFLG, 12 !NFLG, 13 ZFLG, 14 !ZFLG; one cycle -> PREPU.
REQ-014 LDSP: SP <= IRL, STACK_CNT <= 0, flags unchanged -> PREPU.
REQ-015 PUSH: PUSH_DEC SP <= SP-1, CNT+1; PUSH_WR ADDR_SEL=2, WDATA_SEL=0, STORE_MEM until ready -> PREPU.
REQ-016 POP: POP_RD ADDR_SEL=2, MEM_READ, LOAD_AC in ready cycle; POP_INC SP <= SP+1, CNT-1 -> PREPU.
REQ-017 JSR: JSR_DEC as PUSH_DEC; JSR_WR as PUSH_WR with WDATA_SEL=1; JSR_JMP LOAD_PC, PC_SRC=0 -> PREPU.
REQ-018 RTS: RTS_RD ADDR_SEL=2, MEM_READ, LOAD_PC with PC_SRC=1 in ready cycle; RTS_INC as POP_INC.
REQ-019 PUSH/JSR with STACK_CNT==STACK_DEPTH: set STK_OVF, no SP/CNT change, no write, no jump, FETCHL -> PREPU.
REQ-020 POP/RTS with STACK_CNT==0: set STK_UNF, no SP/CNT change, no LOAD_AC/LOAD_PC, FETCHL -> PREPU.
REQ-021 SP arithmetic modulo 2^ADDR_W (0-1 wraps to all-ones; all-ones+1 wraps to 0); wrap is not an error.
REQ-022 All strobes zero in any state/condition not listed; STK_OVF/STK_UNF clear only by reset.

Reset
REQ-023 RESET_N=0 at a rising edge: state START, SP=SP_INIT, STACK_CNT=0, STK_OVF=STK_UNF=0; all strobes 0 while RESET_N=0, including mid-instruction or mid-wait.
REQ-024 First cycle after RESET_N rises is START; PREPU follows.

Structure
REQ-025 Package seq_control_pkg holds state enum (5-bit), opcode localparams 00..19, ADDR_SEL and WDATA_SEL encodings.
REQ-026 Sub-module seq_stack_ptr holds SP, STACK_CNT, full/empty compare and sticky flags; FSM drives its load/inc/dec.

Verification
REQ-027 Reset, then PUSH with SP=255, MEM_READY held 0 three cycles -> SP=254, STORE_MEM high four cycles at ADDR_SEL=2, CNT=1.
REQ-028 LOADSP 0x00 then PUSH -> SP=0xFF (wrap), no STK_OVF.
REQ-029 STACK_DEPTH=2: three PUSHes -> third sets STK_OVF, SP=SP_INIT-2, no third STORE_MEM.
REQ-030 JSR 0x40 from PC 0x10 then RTS -> STORE_MEM with WDATA_SEL=1, LOAD_PC PC_SRC=0; RTS LOAD_PC PC_SRC=1; SP and CNT restored.
REQ-031 POP at CNT=0 -> STK_UNF=1, no LOAD_AC; opcode 0x1C -> ILLEGAL one cycle, next state PREPU.
REQ-032 RESET_N low during JSR_WR wait -> next cycle START, all strobes 0, SP=SP_INIT.
